// File: rtl/stream_max_min_tracker.sv
// Streaming frame max/min tracker.
// Accepts unsigned samples over a valid/ready handshake, folds them into a
// running maximum and minimum, and presents {max, min, count} for each frame
// over an output valid/ready handshake. A frame closes after FRAME_LEN
// samples or on an accepted in_last, whichever comes first. Frames never
// overlap: the input is stalled while a result is waiting to be taken.
module stream_max_min_tracker #(
   parameter int WIDTH     = 4,
   parameter int FRAME_LEN = 8,
   parameter int CNT_W     = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] max_out,
   output logic [WIDTH-1:0] min_out,
   output logic [CNT_W-1:0] count_out
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Frame length at count width, so the end-of-frame compare is width matched.
   localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] max_reg, max_next;
   logic [WIDTH-1:0] min_reg, min_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [CNT_W-1:0] cnt_inc;
   logic             in_ready_reg;
   logic             out_valid_reg;
   logic             accept;

   // Handshake strobes; in_ready_reg depends on state only, never on in_valid.
   assign accept  = in_valid && in_ready_reg;
   assign cnt_inc = cnt_reg + 1'b1;

   // Next-state and datapath update: load on the first sample, fold afterwards.
   always_comb begin
      state_next = state_reg;
      max_next   = max_reg;
      min_next   = min_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               max_next = in_data;
               min_next = in_data;
               cnt_next = CNT_W'(1);
               if (in_last || (FRAME_LEN == 1)) begin
                  state_next = DONE;
               end else begin
                  state_next = ACCUM;
               end
            end
         end
         ACCUM: begin
            if (accept) begin
               // Ties keep the held value, which is numerically the same.
               max_next = (in_data > max_reg) ? in_data : max_reg;
               min_next = (in_data < min_reg) ? in_data : min_reg;
               cnt_next = cnt_inc;
               // in_last on the FRAME_LEN-th sample closes the frame only once.
               if (in_last || (cnt_inc == FRAME_LEN_C)) begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
               cnt_next   = '0;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // State and datapath registers; reset discards any partial frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         max_reg       <= '0;
         min_reg       <= '0;
         cnt_reg       <= '0;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         max_reg       <= max_next;
         min_reg       <= min_next;
         cnt_reg       <= cnt_next;
         in_ready_reg  <= (state_next != DONE);
         out_valid_reg <= (state_next == DONE);
      end
   end

   // Results come straight from the holding registers, stable through DONE.
   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign max_out   = max_reg;
   assign min_out   = min_reg;
   assign count_out = cnt_reg;

endmodule

// File: doc/stream_max_min_tracker.md
Name: stream_max_min_tracker

Overview:
- Sequential counterpart to the team's combinational two-input max/min block.
- Consumes a stream of unsigned samples over a valid/ready handshake and tracks the running maximum and minimum across a frame.
- Presents the frame result (max, min, sample count) on an output valid/ready handshake.
- Sits downstream of sample generators; also used as a self-check monitor for max/min datapaths.

Parameters:
- WIDTH, 4: sample width in bits, unsigned.
- FRAME_LEN, 8: maximum samples per frame, ≥1; a frame ends at FRAME_LEN samples or at in_last, whichever comes first.
- CNT_W, 4: count width; must satisfy 2^CNT_W > FRAME_LEN.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  sample valid.
- in_ready  output  1  tracker can accept a sample.
- in_data  input  WIDTH  sample value, unsigned.
- in_last  input  1  sample is the last of its frame; qualified by in_valid.
- out_valid  output  1  frame result valid.
- out_ready  input  1  consumer accepts the result.
- max_out  output  WIDTH  frame maximum.
- min_out  output  WIDTH  frame minimum.
- count_out  output  CNT_W  number of samples in the frame, 1..FRAME_LEN.

Behaviour:
- Clock and reset:
  - One clock domain.
  - rst_n is asynchronous assert and synchronous release.
  - Reset values: state=IDLE, in_ready=1, out_valid=0, max_out=0, min_out=0, count_out=0, internal count=0.
- Handshakes:
  - Input accepted on a rising edge with in_valid&&in_ready.
  - Output taken on a rising edge with out_valid&&out_ready.
  - in_ready is a registered function of state only; it must not depend on in_valid.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On accept: max_r=min_r=in_data, cnt=1. If in_last or FRAME_LEN==1, go to DONE; else go to ACCUM.
  - ACCUM: in_ready=1. On accept: max_r=(in_data>max_r)?in_data:max_r, min_r=(in_data<min_r)?in_data:min_r, cnt=cnt+1. If in_last or cnt+1==FRAME_LEN, go to DONE. No accept means hold.
  - DONE: in_ready=0, out_valid=1. max_out/min_out/count_out are driven from max_r/min_r/cnt and stay stable until the handshake. On out_ready, go to IDLE and clear cnt.
- Latency:
  - out_valid rises on the first edge after the final sample is accepted.
  - Minimum frame turnaround is 2 cycles: the final accept, then the DONE handshake.
  - No input is accepted while in DONE; there is no overlap of consecutive frames.
- Arithmetic: unsigned compare. Ties leave the register unchanged, which gives the same value.
- Boundary conditions:
  - Single-sample frame: max_out==min_out==sample, count_out=1.
  - All-equal samples: max==min.
  - Extremes 0 and 2^WIDTH-1 must be handled with no wrap.
  - in_last on the FRAME_LEN-th sample ends the frame once; it is not counted twice.
  - in_last while in_valid=0 is ignored.
  - out_ready held high in DONE: result completes in 1 cycle, then IDLE.
  - out_ready asserted outside DONE is ignored.
  - rst_n asserted mid-frame or in DONE: immediate return to reset values; the partial frame is discarded and no out_valid is produced.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> in_ready=1, out_valid=0, max_out/min_out/count_out=0. Release -> first sample is accepted on the next edge.
- Full frame, WIDTH=4, FRAME_LEN=8: samples 5,2,9,2,15,0,7,9 with no in_last, out_ready=1 -> out_valid one cycle after the 8th accept, max_out=15, min_out=0, count_out=8. out_valid is low the following cycle.
- Early termination: samples 6,3,11 with in_last on 11 -> max_out=11, min_out=3, count_out=3. Single sample 4 with in_last -> max=min=4, count=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE -> out_valid and outputs stable, in_ready=0; samples presented in that window are not consumed.
  - Then pulse out_ready -> IDLE next edge.
- Input gaps: frame 1,8,8,8 with in_valid low 2 cycles between samples, in_last on the 4th -> max=8, min=1, count=4, with no spurious accepts.
- Mid-frame reset: after 3 samples of 9,1,14, pulse rst_n low asynchronously -> outputs cleared immediately. Next frame 7 with in_last -> max=min=7, count=1, with no residue from the aborted frame.
